fifo_sync: RTL

Parametrised single-clock synchronous FIFO. It is the successor to the 8-bit, 64-entry strobe-clocked UART buffer. It runs on the system clock with level-sensitive write/read enables, and adds:
- configurable width and depth
- an occupancy count and almost-full/almost-empty thresholds
- a synchronous flush
- sticky overflow/underflow error flags

It sits between bus-side peripherals (UART, SPI, SD) and their serial engines.

---
 rtl/fifo_pkg.sv | 30 +++
 rtl/fifo_ram.sv | 48 ++++
 rtl/fifo_sync.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the synchronous FIFO family:
//   - clog2 constant function used to size pointers and the occupancy count
//   - default geometry/threshold constants used by the UART/SPI instances
//   - fifo_op_e, the per-cycle accepted-operation classification
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH   = 8;
    localparam int unsigned DEFAULT_DEPTH        = 64;
    localparam int unsigned DEFAULT_ALMOST_FULL  = DEFAULT_DEPTH - 4;
    localparam int unsigned DEFAULT_ALMOST_EMPTY = 4;

    // Encoding is {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_RD    = 2'b01,
        OP_WR    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram
// Simple dual-port RAM: one write port, one synchronous read port.
// Kept separate so the storage can map to block RAM or a vendor macro.
// Ports:
//   i_clock    system clock
//   i_reset_n  async active-low reset (read data register only)
//   i_we       write enable
//   i_waddr    write address
//   i_wdata    write data
//   i_re       read enable; rdata updates only when set, otherwise holds
//   i_raddr    read address
//   o_rdata    registered read data
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    localparam int unsigned AW        = clog2(DEPTH)
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [AW-1:0]         i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage has no reset so it can infer block RAM.
    always_ff @(posedge i_clock) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Read-before-write when addresses collide (full with simultaneous R/W).
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_rdata <= '0;
        end else if (i_re) begin
            o_rdata <= mem[i_raddr];
        end
    end

endmodule

// File: rtl/fifo_sync.sv
// fifo_sync
// Parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds, synchronous flush and sticky overflow/underflow flags.
// Ports:
//   i_clock, i_reset_n      clock, async active-low reset
//   i_flush                 sync clear of pointers/count (beats read/write)
//   i_write, i_wdata        level-sensitive write enable and data
//   i_read                  level-sensitive read enable
//   o_rdata, o_rvalid       registered read data, one-cycle valid pulse
//   o_empty, o_full         count == 0 / count == DEPTH
//   o_almost_empty/full     count <= ALMOST_EMPTY / count >= ALMOST_FULL
//   o_count                 occupancy (AW+1 bits)
//   o_overflow, o_underflow sticky error flags
//   i_clear_err             sync clear of the error flags
module fifo_sync
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter int unsigned ALMOST_FULL  = DEPTH - 4,
    parameter int unsigned ALMOST_EMPTY = DEFAULT_ALMOST_EMPTY,
    localparam int unsigned AW          = clog2(DEPTH),
    localparam int unsigned CW          = AW + 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_flush,
    input  logic                  i_write,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_read,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_rvalid,
    output logic                  o_empty,
    output logic                  o_full,
    output logic                  o_almost_empty,
    output logic                  o_almost_full,
    output logic [CW-1:0]         o_count,
    output logic                  o_overflow,
    input  logic                  i_clear_err,
    output logic                  o_underflow
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL   = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] AE_LEVEL   = CW'(ALMOST_EMPTY);

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          rd_ok;
    logic          wr_ok;
    logic          set_ovf;
    logic          set_unf;
    fifo_op_e      op;

    // Status flags decode straight from the registered count.
    always_comb begin
        o_count        = count;
        o_empty        = (count == '0);
        o_full         = (count == FULL_COUNT);
        o_almost_empty = (count <= AE_LEVEL);
        o_almost_full  = (count >= AF_LEVEL);
    end

    // A read at full frees a slot, so the write is accepted alongside it.
    // At empty the read is rejected even if a write arrives (no bypass).
    always_comb begin
        rd_ok   = !i_flush && i_read && !o_empty;
        wr_ok   = !i_flush && i_write && (!o_full || rd_ok);
        set_ovf = !i_flush && i_write && !wr_ok;
        set_unf = !i_flush && i_read && o_empty;
        op      = fifo_op_e'({wr_ok, rd_ok});
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            o_rvalid <= 1'b0;
        end else if (i_flush) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            o_rvalid <= 1'b0;
        end else begin
            o_rvalid <= rd_ok;
            if (wr_ok) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + AW'(1);
            end
            case (op)
                OP_WR:   count <= count + CW'(1);
                OP_RD:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Setting wins over a same-cycle clear.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (set_ovf) begin
                o_overflow <= 1'b1;
            end else if (i_clear_err) begin
                o_overflow <= 1'b0;
            end
            if (set_unf) begin
                o_underflow <= 1'b1;
            end else if (i_clear_err) begin
                o_underflow <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_we      (wr_ok),
        .i_waddr   (wptr),
        .i_wdata   (i_wdata),
        .i_re      (rd_ok),
        .i_raddr   (rptr),
        .o_rdata   (o_rdata)
    );

endmodule
